fir_decimator: RTL and testbench
================================

# fir_decimator

Output stage directly downstream of `fir_filter`. It consumes the filter's full-width signed output `y` and keeps one sample in every `D` valid samples. Each kept sample is rounded and right-shifted, then saturated to a narrow output width. Results are buffered in a small FIFO and presented on a valid/ready stream, so a slower consumer can back-pressure without stalling the filter.

## Interface
- `W_Y`, 12, width of signed input (matches `fir_filter` output width `W_X+W_K+N+1`)
- `W_OUT`, 8, width of signed output sample
- `D`, 4, decimation factor, ≥1
- `SHIFT`, 2, arithmetic right shift applied before saturation, 0..W_Y-1
- `DEPTH`, 4, FIFO depth in entries, power of two, ≥2
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `y`  in  W_Y  signed filter output
- `y_valid`  in  1  `y` is a valid sample this cycle
- `m_data`  out  W_OUT  signed decimated sample (FIFO head)
- `m_valid`  out  1  `m_data` valid
- `m_ready`  in  1  consumer accepts `m_data` this cycle
- `sat`  out  1  one-cycle pulse: the sample entering the FIFO was clipped
- `overflow`  out  1  sticky: a kept sample was dropped because the FIFO was full

## Operation
- Phase counter `ph` runs 0..D-1 and advances only on cycles with `y_valid=1`. It wraps from D-1 to 0.
- A sample is kept when `y_valid=1` and `ph==0`. The first valid sample after reset is therefore kept. With D=1, every valid sample is kept.
- Quantize, computed in W_Y+1 bits:
  - r = (y + 2^(SHIFT-1)) >>> SHIFT, which is round-half-up. With SHIFT=0, r = y.
  - Saturate r to [-2^(W_OUT-1), 2^(W_OUT-1)-1].
- Stage 1 register (`q_data`, `q_valid`, `q_sat`): loaded on every edge. `q_valid` = kept.
- Stage 2 (FIFO push when `q_valid`):
  - If not full, or if full and a pop occurs in the same cycle: write `q_data`. `sat` equals `q_sat` in the cycle after the write.
  - If full with no pop: drop the sample, set `overflow`=1, and assert no `sat`.
- FIFO is first-word-fall-through: `m_data` = head, `m_valid` = not empty. Pop on `m_valid & m_ready`.
- Pushing into an empty FIFO never bypasses: `m_valid` rises the cycle after the write.
- `m_data` is held stable while `m_valid & !m_ready`.
- `overflow` is cleared only by `rst`.
- Reset values: `ph`=0, `q_valid`=0, FIFO empty, `m_valid`=0, `m_data`=0, `sat`=0, `overflow`=0.
- Reset mid-operation: all FIFO contents are discarded and the in-flight stage-1 sample is lost. The first valid sample after `rst` deasserts is kept.

## Timing
- A sample kept at edge k is in stage 1 after k and in the FIFO after k+1. If the FIFO was empty, `m_valid` is high in the cycle following edge k+1, giving a 2-cycle latency.
- Sustained throughput: one output per D valid inputs. The FIFO never overflows while `m_ready` is held high.
- Simultaneous push and pop on a full FIFO: both occur, and the count is unchanged.
- Simultaneous push and pop on a FIFO holding one entry: the head advances to the new entry, and `m_valid` stays high.

## Configuration
- `FIR_DEC_SAT_EN` defined: saturation as above. `sat` pulses on clipped samples.
- Not defined: no saturation. r is truncated to its low W_OUT bits (two's-complement wrap). `sat` is tied to 0.
- Rounding, decimation, the FIFO, and `overflow` are identical in both builds.

## Structure
- Package `fir_dec_pkg`: a typedef for the output sample, and a function `round_shift` (returning W_Y+1 bits).
- The package also holds a function `sat_to_out`, compiled under the macro.
- One sub-module: `sync_fifo`, a generic FWFT FIFO with parameters WIDTH and DEPTH, and push, pop, full, empty ports. `fir_decimator` instantiates it.

## Test plan
All scenarios use defaults (W_Y=12, W_OUT=8, D=4, SHIFT=2, DEPTH=4) unless stated.
- Decimation: `y` = 0,4,8,…,60 on consecutive cycles with `y_valid`=1 and `m_ready`=1 → `m_data` sequence 0,4,8,12. Each output appears 2 cycles after its input (16, 32 and 48 become 4, 8, 12).
- Rounding with D=1:
  - `y`=6 → 2; `y`=5 → 1
  - `y`=-6 → -1; `y`=-7 → -2
- Saturation with D=1:
  - With `FIR_DEC_SAT_EN`: `y`=1000 → 127 with a `sat` pulse; `y`=-2048 → -128 with a `sat` pulse.
  - Without the macro: the same inputs give -6 and 0, and `sat` stays 0.
- Back-pressure: `m_ready`=0, six kept samples with D=1 (`y`=4,8,…,24) → the FIFO holds 1,2,3,4 and `overflow`=1. Raising `m_ready` then yields 1,2,3,4 in order, after which `m_valid`=0.
- Input gaps: alternate `y_valid` 1/0 over ramp 0,4,8,… → `ph` advances only on valid cycles, and outputs equal scenario 1.
- Reset mid-run: assert `rst` asynchronously with 2 entries queued → `m_valid`, `sat` and `overflow` drop to 0 immediately. The next valid `y`=20 after release → output 5.

Source files
------------

// File: rtl/fir_dec_pkg.sv
// Shared types and quantization helpers for fir_decimator.
// The saturating helper is compiled only when FIR_DEC_SAT_EN is defined.
package fir_dec_pkg;

    localparam int unsigned W_Y   = 12;
    localparam int unsigned W_OUT = 8;
    localparam int unsigned W_R   = W_Y + 1;

    typedef logic signed [W_OUT-1:0] out_t;
    typedef logic signed [W_R-1:0]   r_t;

    // Stage-1 payload: quantized sample plus its clip flag
    typedef struct packed {
        logic clipped;
        out_t data;
    } q_t;

    // Round-half-up arithmetic right shift, one guard bit above W_Y
    function automatic r_t round_shift(input logic signed [W_Y-1:0] y, input int unsigned shift);
        r_t ext;
        r_t bias;
        ext = {y[W_Y-1], y};
        if (shift == 0) begin
            return ext;
        end
        bias = r_t'(1) << (shift - 1);
        return (ext + bias) >>> shift;
    endfunction

`ifdef FIR_DEC_SAT_EN
    localparam r_t OUT_MAX = r_t'((1 << (W_OUT - 1)) - 1);
    localparam r_t OUT_MIN = -OUT_MAX - r_t'(1);

    function automatic q_t sat_to_out(input r_t r);
        q_t res;
        res.clipped = 1'b0;
        res.data    = W_OUT'(r);
        if (r > OUT_MAX) begin
            res.data    = W_OUT'(OUT_MAX);
            res.clipped = 1'b1;
        end else if (r < OUT_MIN) begin
            res.data    = W_OUT'(OUT_MIN);
            res.clipped = 1'b1;
        end
        return res;
    endfunction
`endif

endpackage

// File: rtl/fir_decimator_if.sv
// Input sample stream and decimated output stream of fir_decimator.
interface fir_dec_if;
    import fir_dec_pkg::*;

    logic signed [W_Y-1:0] y;
    logic                  y_valid;
    out_t                  m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  sat;
    logic                  overflow;

    modport slave  (input  y, y_valid, m_ready,
                    output m_data, m_valid, sat, overflow);
    modport master (output y, y_valid, m_ready,
                    input  m_data, m_valid, sat, overflow);
endinterface

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop & ~empty_q;
        do_push  = push & (~full_q | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Storage is cleared on reset so the head reads zero while empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/fir_decimator.sv
// Keeps one of every D valid filter samples, rounds/shifts/quantizes it and
// buffers it in an FWFT FIFO. Saturation is enabled by FIR_DEC_SAT_EN.
module fir_decimator
    import fir_dec_pkg::*;
#(
    parameter int unsigned D     = 4,
    parameter int unsigned SHIFT = 2,
    parameter int unsigned DEPTH = 4
) (
    input logic      clk,
    input logic      rst,
    fir_dec_if.slave bus
);
    localparam int unsigned PH_W = (D > 1) ? $clog2(D) : 1;

    logic [PH_W-1:0] ph_q, ph_d;
    q_t              q_q, q_d;
    logic            q_valid_q, q_valid_d;
    logic            sat_q, sat_d;
    logic            overflow_q, overflow_d;
    r_t              r;
    logic            keep;
    logic            push, pop;
    logic            fifo_full, fifo_empty;
    out_t            fifo_dout;

    always_comb begin
        keep = bus.y_valid && (ph_q == '0);
        ph_d = ph_q;
        if (bus.y_valid) begin
            ph_d = (ph_q == PH_W'(D - 1)) ? '0 : ph_q + PH_W'(1);
        end
        r = round_shift(bus.y, SHIFT);
`ifdef FIR_DEC_SAT_EN
        q_d = sat_to_out(r);
`else
        q_d.clipped = 1'b0;
        q_d.data    = W_OUT'(r);
`endif
        q_valid_d  = keep;
        pop        = ~fifo_empty & bus.m_ready;
        // A full FIFO still accepts the sample when the head leaves this cycle
        push       = q_valid_q & (~fifo_full | pop);
        sat_d      = push & q_q.clipped;
        overflow_d = overflow_q | (q_valid_q & fifo_full & ~pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_q       <= '0;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
            sat_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            ph_q       <= ph_d;
            q_q        <= q_d;
            q_valid_q  <= q_valid_d;
            sat_q      <= sat_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (W_OUT),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (q_q.data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.m_data   = fifo_dout;
    assign bus.m_valid  = ~fifo_empty;
    assign bus.sat      = sat_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_fir_decimator.sv
// Scoreboard bench for fir_decimator: a D=4 and a D=1 instance share clk/rst;
// expected outputs are queued by the stimulus and popped by a negedge monitor.
module tb_fir_decimator;
    import fir_dec_pkg::*;

    logic clk;
    logic rst;

    fir_dec_if a_if ();
    fir_dec_if b_if ();

    fir_decimator #(.D(4), .SHIFT(2), .DEPTH(4)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
    fir_decimator #(.D(1), .SHIFT(2), .DEPTH(4)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_a[$];
    int exp_b[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every accepted output is compared against the queue head
    always @(negedge clk) begin
        if (!rst) begin
            if (a_if.m_valid && a_if.m_ready) begin
                if (exp_a.size() == 0) chk("a_unexpected_out", int'(a_if.m_data), -9999);
                else chk("a_data", int'(a_if.m_data), exp_a.pop_front());
            end
            if (b_if.m_valid && b_if.m_ready) begin
                if (exp_b.size() == 0) chk("b_unexpected_out", int'(b_if.m_data), -9999);
                else chk("b_data", int'(b_if.m_data), exp_b.pop_front());
            end
        end
    end

    int rnd_in  [4] = '{6, 5, -6, -7};
    int rnd_exp [4] = '{2, 1, -1, -2};
    int sat_in  [2] = '{1000, -2048};
`ifdef FIR_DEC_SAT_EN
    int sat_exp [2] = '{127, -128};
    int sat_flag    = 1;
`else
    int sat_exp [2] = '{-6, 0};
    int sat_flag    = 0;
`endif

    initial begin
        rst          = 1'b1;
        a_if.y       = '0;
        a_if.y_valid = 1'b0;
        a_if.m_ready = 1'b1;
        b_if.y       = '0;
        b_if.y_valid = 1'b0;
        b_if.m_ready = 1'b1;
        #12;
        chk("rst_m_valid", int'(a_if.m_valid), 0);
        chk("rst_m_data", int'(a_if.m_data), 0);
        chk("rst_sat", int'(a_if.sat), 0);
        chk("rst_overflow", int'(a_if.overflow), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Decimation by 4 over a ramp, with first-output latency
        exp_a.push_back(0); exp_a.push_back(4); exp_a.push_back(8); exp_a.push_back(12);
        for (int i = 0; i < 16; i++) begin
            a_if.y       = W_Y'(4 * i);
            a_if.y_valid = 1'b1;
            cyc(1);
            if (i == 0) chk("lat_m_valid_low", int'(a_if.m_valid), 0);
            if (i == 1) begin
                chk("lat_m_valid_high", int'(a_if.m_valid), 1);
                chk("lat_m_data", int'(a_if.m_data), 0);
            end
        end
        a_if.y_valid = 1'b0;
        cyc(4);
        chk("a_no_overflow", int'(a_if.overflow), 0);

        // Same ramp with idle cycles carrying junk data in between
        exp_a.push_back(0); exp_a.push_back(4); exp_a.push_back(8); exp_a.push_back(12);
        for (int i = 0; i < 16; i++) begin
            a_if.y       = W_Y'(4 * i);
            a_if.y_valid = 1'b1;
            cyc(1);
            a_if.y       = W_Y'(999);
            a_if.y_valid = 1'b0;
            cyc(1);
        end
        cyc(4);

        // Round-half-up on D=1
        for (int i = 0; i < 4; i++) begin
            exp_b.push_back(rnd_exp[i]);
            b_if.y       = W_Y'(rnd_in[i]);
            b_if.y_valid = 1'b1;
            cyc(1);
        end
        b_if.y_valid = 1'b0;
        cyc(4);

        // Clipping / wrap, with the sat pulse one cycle after the FIFO write
        for (int i = 0; i < 2; i++) begin
            exp_b.push_back(sat_exp[i]);
            b_if.y       = W_Y'(sat_in[i]);
            b_if.y_valid = 1'b1;
            cyc(1);
            b_if.y_valid = 1'b0;
            cyc(1);
            chk("sat_pulse", int'(b_if.sat), sat_flag);
            cyc(1);
            chk("sat_cleared", int'(b_if.sat), 0);
        end
        cyc(2);

        // Back-pressure: six kept samples into a 4-deep FIFO
        b_if.m_ready = 1'b0;
        exp_b.push_back(1); exp_b.push_back(2); exp_b.push_back(3); exp_b.push_back(4);
        for (int i = 1; i <= 6; i++) begin
            b_if.y       = W_Y'(4 * i);
            b_if.y_valid = 1'b1;
            cyc(1);
        end
        b_if.y_valid = 1'b0;
        cyc(2);
        chk("bp_overflow", int'(b_if.overflow), 1);
        chk("bp_m_valid", int'(b_if.m_valid), 1);
        chk("bp_head_held", int'(b_if.m_data), 1);
        b_if.m_ready = 1'b1;
        cyc(6);
        chk("bp_drained", int'(b_if.m_valid), 0);
        chk("bp_overflow_sticky", int'(b_if.overflow), 1);

        // Reset with two entries queued on the D=4 instance
        a_if.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_if.y       = W_Y'((i == 0) ? 40 : (i == 4) ? 44 : i);
            a_if.y_valid = 1'b1;
            cyc(1);
        end
        a_if.y_valid = 1'b0;
        cyc(3);
        chk("pre_rst_m_valid", int'(a_if.m_valid), 1);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_m_valid", int'(a_if.m_valid), 0);
        chk("async_rst_m_data", int'(a_if.m_data), 0);
        chk("async_rst_sat", int'(a_if.sat), 0);
        chk("async_rst_overflow", int'(b_if.overflow), 0);
        cyc(2);
        rst          = 1'b0;
        a_if.m_ready = 1'b1;
        exp_a.push_back(5);
        a_if.y       = W_Y'(20);
        a_if.y_valid = 1'b1;
        cyc(1);
        a_if.y_valid = 1'b0;
        cyc(4);

        for (int i = 0; i < 50 && (exp_a.size() + exp_b.size()) != 0; i++) cyc(1);
        chk("scoreboard_drained", exp_a.size() + exp_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
